// File: rtl/counter_pkg.sv
// Shared definitions for the counter event receiver: FSM encoding and
// parameter legality checks.
package counter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StGap  = 2'd2
    } state_e;

    localparam int unsigned GapCntW = 4;

    function automatic bit params_legal(input int unsigned sync_stages,
                                        input int unsigned cnt_w,
                                        input int unsigned gap_cyc);
        return (sync_stages >= 2) && (sync_stages <= 4) &&
               (cnt_w >= 4) && (cnt_w <= 32) &&
               (gap_cyc >= 1) && (gap_cyc <= 15);
    endfunction

endpackage

// File: rtl/counter_sync_bit.sv
// Multi-flop single-bit synchronizer with synchronous active-high reset.
// Also used on the source side for the ack return path.
module counter_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/counter_event_rx.sv
// Destination side of the four-phase req/ack handshake: turns each accepted
// request into one event pulse and counts events with wrap, clear and snapshot.
module counter_event_rx
    import counter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GAP_CYC     = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic             i_clr,
    input  logic             i_snap,
    output logic             o_ack,
    output logic             o_evt_pulse,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_snap_cnt,
    output logic             o_ovf,
    output logic             o_busy
);

    if (!params_legal(SYNC_STAGES, CNT_W, GAP_CYC)) begin : g_bad_params
        $error("counter_event_rx: illegal SYNC_STAGES/CNT_W/GAP_CYC");
    end

    localparam logic [GapCntW-1:0] GapLoad = GapCntW'(GAP_CYC - 1);

    logic               req_s;
    logic               evt_fire;
    state_e             state_q;
    logic [GapCntW-1:0] gap_q;
    logic               ack_q, pulse_q, busy_q, ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base, snap_q, snap_d;

    counter_sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk_i(i_clk),
        .rst_i(i_rst),
        .d_i  (i_req),
        .q_o  (req_s)
    );

    // The edge that leaves IDLE is the one that raises ack, pulses and counts.
    assign evt_fire = (state_q == StIdle) && req_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            gap_q   <= '0;
            ack_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_s) begin
                        state_q <= StHold;
                        ack_q   <= 1'b1;
                        pulse_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StHold: begin
                    if (!req_s) begin
                        state_q <= StGap;
                        ack_q   <= 1'b0;
                        gap_q   <= GapLoad;
                    end
                end
                StGap: begin
                    if (gap_q == '0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Clear applies before a same-edge event; snapshot sees the pre-edge count.
    always_comb begin
        cnt_base = i_clr ? '0 : cnt_q;
        ovf_d    = i_clr ? 1'b0 : ovf_q;
        cnt_d    = cnt_base;
        snap_d   = i_snap ? cnt_q : snap_q;
        if (evt_fire) begin
            cnt_d = cnt_base + CNT_W'(1);
            if (&cnt_base) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            snap_q <= snap_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_evt_pulse = pulse_q;
    assign o_cnt       = cnt_q;
    assign o_snap_cnt  = snap_q;
    assign o_ovf       = ovf_q;
    assign o_busy      = busy_q;

endmodule

// File: doc/counter_event_rx.md
Name: counter_event_rx

Overview:
Destination-end receiver of the counter event level/ack handshake, clocked by the destination clock.
- Synchronizes the source's held request level and detects each new request.
- Returns an ack level so the source can clear its hold flop (four-phase: req↑, ack↑, req↓, ack↓).
- Emits one single-cycle event pulse per handshake and accumulates events in a wrapping counter with sticky overflow, clear and snapshot.
- Sits between the source-domain request holder and the destination counter logic.

Parameters:
SYNC_STAGES, 2, synchronizer flops on i_req (legal 2..4)
CNT_W, 16, event counter width (legal 4..32)
GAP_CYC, 2, minimum cycles ack held low after req deasserts before a new req is accepted (legal 1..15)

Ports:
i_clk  in  1  destination clock
i_rst  in  1  synchronous active-high reset
i_req  in  1  request level from source domain, asynchronous to i_clk
i_clr  in  1  clear counter and overflow (single-cycle, i_clk domain)
i_snap  in  1  capture counter into snapshot register
o_ack  out  1  ack level back to source domain (registered, glitch-free)
o_evt_pulse  out  1  one-cycle pulse per accepted request
o_cnt  out  CNT_W  live event count
o_snap_cnt  out  CNT_W  snapshot of count
o_ovf  out  1  sticky counter wrap flag
o_busy  out  1  high while FSM not in IDLE

Behaviour:
- Reset (i_rst high at a posedge):
  - Synchronizer chain, FSM (IDLE), gap counter, o_ack, o_evt_pulse, o_cnt, o_snap_cnt, o_ovf, o_busy all go to 0.
  - Reset mid-handshake drops o_ack immediately. The source must tolerate this; its request stays high and is re-accepted after reset as a new event.
- Synchronizer:
  - req_s = last stage of a SYNC_STAGES flop chain on i_req.
  - No other logic touches i_req directly.
- FSM states:
  - IDLE: ack=0. If req_s=1 → HOLD. The transition edge sets o_ack=1 and o_evt_pulse=1 for exactly one cycle.
  - HOLD: ack=1, no pulse. If req_s=0 → GAP, o_ack=0 on that edge, gap counter loaded with GAP_CYC-1.
  - GAP: ack=0. Decrement each cycle. When gap count=0 → IDLE.
  - A req_s=1 during GAP is not lost. It is accepted from IDLE on the following cycle.
- Latency:
  - i_req rising, sampled at edge N, gives req_s=1 after edge N+SYNC_STAGES-1.
  - o_ack and o_evt_pulse go high after edge N+SYNC_STAGES, i.e. 3 edges with defaults.
- Counter:
  - On the edge that asserts o_evt_pulse, o_cnt increments, so the new value is visible in the same cycle as the pulse.
  - All-ones +1 wraps to 0 and sets o_ovf=1 (sticky).
- i_clr:
  - Sets o_cnt=0 and o_ovf=0.
  - If i_clr coincides with a pulse-generating edge, o_cnt=1 and o_ovf=0; clear applies first, then the event counts.
- i_snap:
  - o_snap_cnt captures o_cnt as it was before any same-edge increment or clear.
  - i_snap, i_clr and an event on the same edge: snapshot gets the old value, o_cnt=1.
- o_busy = (state != IDLE).
- Invariant: o_evt_pulse is never high on two consecutive cycles. At most one pulse per ack high phase.

Decomposition:
- Shared package counter_pkg:
  - FSM state encoding (IDLE=2'd0, HOLD=2'd1, GAP=2'd2).
  - Legal-range checks for SYNC_STAGES, CNT_W and GAP_CYC.
- Sub-module counter_sync_bit:
  - Parameterized SYNC_STAGES flop chain with synchronous active-high reset.
  - Reused by the source-side holder for the ack return path.

Test Plan:
1. Reset then single event: i_req 0→1 held, defaults → o_ack=1 and o_evt_pulse=1 three edges after sampling, o_cnt=1. Drop i_req → o_ack=0 three edges later. FSM back in IDLE after GAP_CYC=2 further cycles.
2. Back-to-back requests: re-raise i_req one cycle after o_ack falls → second pulse only after GAP completes, o_cnt=2. Exactly 2 pulses total, never adjacent.
3. Wrap: CNT_W=4, 16 handshakes → o_cnt=0, o_ovf=1. A 17th handshake → o_cnt=1, o_ovf still 1. Pulse i_clr → o_cnt=0, o_ovf=0.
4. Simultaneous clr/snap/event: o_cnt=5, assert i_clr and i_snap on the pulse edge → o_snap_cnt=5, o_cnt=1, o_ovf=0.
5. Reset mid-operation: assert i_rst in HOLD with i_req still high → next cycle o_ack=0, o_cnt=0, o_busy=0. After release, the request is re-accepted with o_cnt=1 after SYNC_STAGES+1 edges.
6. Glitch immunity: i_req high for 1 cycle only (SYNC_STAGES=2) → at most one pulse. Ack rises and falls once, and the FSM returns to IDLE with o_cnt exactly +1 or +0 and never +2.
